// File: rtl/tiny1_soc_pkg.sv
// Shared tiny1 SoC definitions: mmap address bit, read-owner and arbiter state encodings.
package tiny1_soc_pkg;

   localparam int MMAP_BIT = 15;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_C    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   typedef enum logic {
      ARB_NORM  = 1'b0,
      ARB_FORCE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/tiny1_starve_cnt.sv
// Saturating starvation counter; hit flags the last denied cycle before D must be forced through.
module tiny1_starve_cnt #(
   parameter int LIMIT = 8,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/tiny1_ram_arb.sv
// ram16k arbiter between the tiny1 core (fixed priority) and the debug/loader DMA port.
//
//   state     | meaning
//   ARB_NORM  | core owns RAM when it asks; D takes idle RAM cycles
//   ARB_FORCE | one-cycle core hold; D granted if still requesting
module tiny1_ram_arb
   import tiny1_soc_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] c_addr,
   input  logic [15:0] c_wdata,
   input  logic        c_wr,
   input  logic        c_rd,
   output logic [15:0] c_rdata,
   output logic        c_hold,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [15:0] d_rdata,
   output logic        d_err,
   output logic [13:0] ram_addr,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout,
   output logic        ram_we,
   output logic        ram_re
);

   arb_state_t state;
   owner_t     rd_owner;
   logic       core_ram;
   logic       core_gnt;
   logic       d_ram;
   logic       cnt_inc;
   logic       cnt_clr;
   logic       starve_hit;
   logic       unused_addr_lsb;

   assign unused_addr_lsb = c_addr[0] ^ d_addr[0];

   // rst also gates the grant path so every strobe reads 0 while reset is held
   always_comb begin
      core_ram = rst && (c_rd || c_wr) && !c_addr[MMAP_BIT];
      core_gnt = core_ram && (state == ARB_NORM);
      d_gnt    = rst && d_req && !core_gnt;
      d_err    = d_gnt && d_addr[MMAP_BIT];
      d_ram    = d_gnt && !d_addr[MMAP_BIT];
      cnt_inc  = core_gnt && d_req;
      cnt_clr  = d_gnt || (state == ARB_FORCE);

      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (core_gnt) begin
         ram_re   = c_rd;
         ram_we   = c_wr && !c_rd;
         ram_addr = c_addr[MMAP_BIT-1:1];
         ram_din  = c_wdata;
      end else if (d_ram) begin
         ram_re   = !d_we;
         ram_we   = d_we;
         ram_addr = d_addr[MMAP_BIT-1:1];
         ram_din  = d_wdata;
      end
   end

   tiny1_starve_cnt #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .hit (starve_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARB_NORM;
         rd_owner <= OWN_NONE;
      end else begin
         case (state)
            ARB_NORM:  if (cnt_inc && starve_hit) state <= ARB_FORCE;
            ARB_FORCE: state <= ARB_NORM;
            default:   state <= ARB_NORM;
         endcase

         if (core_gnt && c_rd) begin
            rd_owner <= OWN_C;
         end else if (d_ram && !d_we) begin
            rd_owner <= OWN_D;
         end else begin
            rd_owner <= OWN_NONE;
         end
      end
   end

   assign c_hold   = (state == ARB_FORCE);
   assign d_rvalid = (rd_owner == OWN_D);
   assign d_rdata  = ram_dout;
   assign c_rdata  = ram_dout;

endmodule

// File: tb/tb_tiny1_ram_arb.sv
// Bench for tiny1_ram_arb: directed scenarios plus random traffic against a cycle-level reference model.
module tb_tiny1_ram_arb;

   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] c_addr, c_wdata, c_rdata;
   logic        c_wr, c_rd, c_hold;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [15:0] d_addr, d_wdata, d_rdata;
   logic [13:0] ram_addr;
   logic [15:0] ram_din;
   logic [15:0] ram_dout = 16'h0;
   logic        ram_we, ram_re;

   logic [15:0] mem     [0:16383];
   logic [15:0] ref_mem [0:16383];

   int checks   = 0;
   int failures = 0;

   int wait_cnt  = 0;
   bit force_now = 1'b0;
   bit m_dgnt    = 1'b0;
   bit obs_dgnt  = 1'b0;
   bit obs_hold  = 1'b0;

   always #5 clk = ~clk;

   tiny1_ram_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_wr     (c_wr),
      .c_rd     (c_rd),
      .c_rdata  (c_rdata),
      .c_hold   (c_hold),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .d_err    (d_err),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .ram_we   (ram_we),
      .ram_re   (ram_re)
   );

   // ram16k stand-in: one-cycle read latency
   always @(posedge clk) begin
      if (ram_re) ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      c_rd = 1'b0; c_wr = 1'b0; c_addr = 16'h0; c_wdata = 16'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
   endtask

   task automatic set_d(input bit we, input logic [15:0] addr, input logic [15:0] data);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = data;
   endtask

   // Called with inputs driven just after a rising edge; checks this cycle and the read return.
   task automatic run_cycle();
      bit          core_ram, e_hold, e_dg, e_err, e_we, e_re, rd_d, rd_c;
      logic [13:0] e_addr;
      logic [15:0] e_din, rd_data;
      e_dg = 0; e_err = 0; e_we = 0; e_re = 0; rd_d = 0; rd_c = 0;
      e_addr = '0; e_din = '0;
      #3;
      core_ram = (c_rd || c_wr) && !c_addr[15];
      e_hold   = force_now;
      if (force_now) begin
         e_dg      = d_req;
         wait_cnt  = 0;
         force_now = 0;
      end else if (core_ram) begin
         e_re   = c_rd;
         e_we   = c_wr && !c_rd;
         e_addr = c_addr[14:1];
         e_din  = c_wdata;
         rd_c   = c_rd;
         if (d_req) begin
            wait_cnt++;
            if (wait_cnt >= LIMIT) force_now = 1;
         end
      end else begin
         e_dg = d_req;
      end
      if (e_dg) begin
         wait_cnt = 0;
         if (d_addr[15]) begin
            e_err = 1;
         end else begin
            e_we   = d_we;
            e_re   = !d_we;
            e_addr = d_addr[14:1];
            e_din  = d_wdata;
            rd_d   = !d_we;
         end
      end
      obs_dgnt = d_gnt;
      obs_hold = c_hold;
      m_dgnt   = e_dg;
      check_eq("c_hold", 32'(c_hold), 32'(e_hold));
      check_eq("d_gnt",  32'(d_gnt),  32'(e_dg));
      check_eq("d_err",  32'(d_err),  32'(e_err));
      check_eq("ram_we", 32'(ram_we), 32'(e_we));
      check_eq("ram_re", 32'(ram_re), 32'(e_re));
      if (e_we || e_re) check_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) check_eq("ram_din", 32'(ram_din), 32'(e_din));
      rd_data = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_din;
      @(posedge clk);
      #1;
      check_eq("d_rvalid", 32'(d_rvalid), 32'(rd_d));
      if (rd_d) check_eq("d_rdata", 32'(d_rdata), 32'(rd_data));
      if (rd_c) check_eq("c_rdata", 32'(c_rdata), 32'(rd_data));
   endtask

   // Asserts reset with busy inputs, checks the quiet outputs, then releases after the next edge.
   task automatic apply_reset();
      rst = 1'b0;
      c_rd = 1'b1; c_addr = 16'h0004;
      set_d(1'b0, 16'h0010, 16'h0);
      #1;
      check_eq("rst_c_hold",   32'(c_hold),   32'(0));
      check_eq("rst_d_gnt",    32'(d_gnt),    32'(0));
      check_eq("rst_d_err",    32'(d_err),    32'(0));
      check_eq("rst_d_rvalid", 32'(d_rvalid), 32'(0));
      check_eq("rst_ram_we",   32'(ram_we),   32'(0));
      check_eq("rst_ram_re",   32'(ram_re),   32'(0));
      check_eq("rst_ram_addr", 32'(ram_addr), 32'(0));
      check_eq("rst_d_rdata",  32'(d_rdata),  32'(ram_dout));
      wait_cnt = 0; force_now = 0; m_dgnt = 0;
      set_idle();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Core reads every cycle with D pending; D should first be granted on cycle LIMIT+1 under c_hold.
   task automatic starve_run(input string tag);
      int got_n = 0;
      c_rd = 1'b1; c_addr = 16'h0100;
      set_d(1'b1, 16'h0030, 16'h5A5A);
      for (int n = 1; n <= 20; n++) begin
         run_cycle();
         if (obs_dgnt) begin
            got_n = n;
            check_eq({tag, "_hold"}, 32'(obs_hold), 32'(1));
            break;
         end
      end
      check_eq({tag, "_cycles"}, 32'(got_n), 32'(LIMIT + 1));
      d_req = 1'b0;
      run_cycle();
      check_eq({tag, "_release"}, 32'(obs_hold), 32'(0));
      c_rd = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) begin
         mem[i] = 16'h0;
         ref_mem[i] = 16'h0;
      end
      set_idle();
      apply_reset();

      // D write then read-back with core idle
      set_d(1'b1, 16'h0010, 16'h1234);
      run_cycle();
      set_d(1'b0, 16'h0010, 16'h0);
      run_cycle();
      set_idle();
      run_cycle();

      starve_run("starve");

      // core mmap write leaves RAM to a D read
      c_wr = 1'b1; c_addr = 16'h8006; c_wdata = 16'h00AA;
      set_d(1'b0, 16'h0020, 16'h0);
      run_cycle();
      set_idle();

      // D mmap access is granted with d_err and never touches RAM
      set_d(1'b0, 16'h8200, 16'h0);
      run_cycle();
      set_idle();
      run_cycle();

      // three back-to-back D reads of preloaded words
      for (int i = 0; i < 3; i++) begin
         mem[i] = 16'(i + 1);
         ref_mem[i] = 16'(i + 1);
      end
      for (int i = 0; i < 3; i++) begin
         set_d(1'b0, 16'(2 * i), 16'h0);
         run_cycle();
      end
      set_idle();
      run_cycle();

      // reset right after a D read grant drops the pending read
      set_d(1'b0, 16'h0002, 16'h0);
      run_cycle();
      apply_reset();
      starve_run("starve_after_rst");

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!(d_req && !m_dgnt)) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = 1'($urandom);
            d_addr  = {($urandom_range(0, 7) == 0), 8'h00, 6'($urandom), 1'($urandom)};
            d_wdata = 16'($urandom);
         end
         c_rd    = ($urandom_range(0, 3) != 0);
         c_wr    = ($urandom_range(0, 2) == 0);
         c_addr  = {($urandom_range(0, 5) == 0), 8'h00, 6'($urandom), 1'($urandom)};
         c_wdata = 16'($urandom);
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tiny1_ram_arb.md
Name: tiny1_ram_arb

Overview:
- Arbitrates the single-port 16-bit ram16k between two requesters: the tiny1 core (port C) and a debug/loader DMA port (port D, host-driven image load and readback).
- Sits between tiny1_core and ram16k in tiny1_soc.
- Core has fixed priority; D uses idle RAM cycles.
- A starvation counter forces a one-cycle core hold so D always makes progress.
- Memory-mapped I/O accesses (address bit 15 set) never reach RAM.

Parameters:
- STARVE_LIMIT, 8, consecutive cycles of D waiting before a forced D grant (range 1..255).
- CNT_W, 8, width of the starvation counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- c_addr  in  16  core byte address; bit 15 = mmap
- c_wdata  in  16  core write data
- c_wr  in  1  core write strobe
- c_rd  in  1  core read strobe
- c_rdata  out  16  RAM read data to core
- c_hold  out  1  core must hold its current access and retry next cycle
- d_req  in  1  D access request
- d_we  in  1  D write (1) / read (0)
- d_addr  in  16  D byte address
- d_wdata  in  16  D write data
- d_gnt  out  1  D access accepted this cycle
- d_rvalid  out  1  D read data valid
- d_rdata  out  16  D read data
- d_err  out  1  D addressed mmap space; access dropped
- ram_addr  out  14  RAM word address (byte address bits [14:1])
- ram_din  out  16  RAM write data
- ram_dout  in  16  RAM read data, 1-cycle latency
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable

Behaviour:
- Reset (rst=0, async): state=NORM, counter=0, rd_owner=NONE. All outputs 0 except c_rdata and d_rdata, which pass ram_dout through.
- Core RAM request: c_rd|c_wr with c_addr[15]=0. Core mmap requests and idle core cycles leave RAM free.
- c_rd and c_wr both set: read wins; ram_we=0.
- FSM state NORM:
  - Core RAM request present: the core drives the RAM. d_gnt=0; counter increments (saturating) if d_req=1.
  - RAM free and d_req=1: D drives the RAM; d_gnt=1; counter cleared.
  - Counter reaching STARVE_LIMIT-1 while still denied: next state FORCE.
- FSM state FORCE (exactly one cycle):
  - c_hold=1; no core RAM access. c_hold is asserted regardless of whether the core requests.
  - D granted if d_req=1; counter cleared; next state NORM.
  - If d_req dropped, FORCE still lasts one cycle and nothing is granted.
- c_hold is combinational from state only, with no path from the inputs.
- d_gnt is combinational. D keeps d_req/d_we/d_addr/d_wdata stable until d_gnt.
- Read return: rd_owner register records C or D on each granted read.
  - d_rvalid=1 in the cycle after a D read grant; d_rdata=ram_dout.
  - c_rdata=ram_dout always; the core samples it the cycle after its read.
- D mmap address (d_addr[15]=1): d_gnt=1 and d_err=1 for one cycle. No RAM access and no d_rvalid. Arbitration is unchanged otherwise, so it happens only when D would have been granted.
- Back-to-back D grants: allowed every free cycle. d_rvalid pipelines and may coincide with a new d_gnt.
- Writes: ram_din comes from the granted requester. Write ordering equals grant order; no reordering or forwarding.
- Reset mid-read: a pending d_rvalid is discarded.

Decomposition:
- Shared package tiny1_soc_pkg:
  - MMAP_BIT=15
  - owner encoding (OWN_NONE=0, OWN_C=1, OWN_D=2)
  - arb state encoding (ARB_NORM, ARB_FORCE)
- Sub-module tiny1_starve_cnt: saturating counter with clear/inc/limit-hit output. Everything else stays flat.

Test Plan:
- Core idle, D writes 0x1234 to byte address 0x0010 -> d_gnt same cycle, ram_we=1, ram_addr=0x0008. A following D read of 0x0010 gives d_rvalid next cycle with d_rdata=0x1234.
- Core reads RAM every cycle, d_req held (STARVE_LIMIT=8) -> d_gnt=0 for 8 cycles, then c_hold=1 and d_gnt=1 in cycle 9. Counter returns to 0; c_hold=0 in cycle 10.
- Core writes 0x00AA to mmap address 0x8006 while D reads 0x0020 -> D granted the same cycle, ram_we=0, c_hold=0.
- D request to 0x8200 -> d_gnt=1 and d_err=1, ram_re=0, ram_we=0, d_rvalid=0 next cycle.
- Three back-to-back D reads of 0x0000, 0x0002, 0x0004 (preloaded 1,2,3) with core idle -> d_rvalid high 3 consecutive cycles, data 1,2,3.
- rst driven low the cycle after a D read grant -> d_rvalid=0, c_hold=0, state=NORM. The counter is 0 after release.
